// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: default datapath width and divider state encoding.
package arith_pkg;

    localparam int ARITH_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIN  = 2'd2
    } div_state_e;

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake and operand/result bundle for the sequential divider.
interface seq_restoring_divider_if
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/fulladder.sv
// One-bit full adder cell shared with the carry-save adder blocks.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/seq_restoring_divider_div_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left, trial-subtract dsr,
// keep the difference and set the quotient bit when it is non-negative.
module div_step
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH:0]   rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);
    logic [WIDTH:0]   sh_rem;
    logic [WIDTH:0]   sub_b;
    logic [WIDTH:0]   trial;
    logic [WIDTH+1:0] carry;
    logic             unused_cout;
    logic             unused_rem_msb;

    // rem < dsr holds between steps, so the top remainder bit is always shifted out as zero
    assign sh_rem   = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign sub_b    = ~{1'b0, dsr};
    assign carry[0] = 1'b1;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
        fulladder u_fa (
            .a    (sh_rem[i]),
            .b    (sub_b[i]),
            .cin  (carry[i]),
            .s    (trial[i]),
            .cout (carry[i+1])
        );
    end

    assign unused_cout    = carry[WIDTH+1];
    assign unused_rem_msb = rem[WIDTH];

    always_comb begin
        if (!trial[WIDTH]) begin
            rem_nxt = trial;
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = sh_rem;
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned radix-2 restoring divider, one quotient bit per clock.
// state    | meaning
// DIV_IDLE | waiting for start; results held
// DIV_RUN  | iterating, cnt_q steps remaining
// DIV_FIN  | publish results (or divide-by-zero result), pulse done
module seq_restoring_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH,
    parameter int CNT_W = 6
) (
    input logic                   clk,
    input logic                   rst,
    seq_restoring_divider_if.slave div_if
);
    div_state_e       state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zdiv_q, zdiv_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .dsr     (dsr_q),
        .rem_nxt (step_rem),
        .quo_nxt (step_quo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= DIV_IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            cnt_q       <= '0;
            zdiv_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            cnt_q       <= cnt_d;
            zdiv_q      <= zdiv_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (div_if.start) state_d = (div_if.divisor == '0) ? DIV_FIN : DIV_RUN;
            DIV_RUN:  if (cnt_q == CNT_W'(1)) state_d = DIV_FIN;
            DIV_FIN:  state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_comb begin
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        cnt_d       = cnt_q;
        zdiv_d      = zdiv_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        case (state_q)
            DIV_IDLE: begin
                if (div_if.start) begin
                    rem_d  = '0;
                    quo_d  = div_if.dividend;
                    dsr_d  = div_if.divisor;
                    cnt_d  = CNT_W'(WIDTH);
                    zdiv_d = (div_if.divisor == '0);
                    busy_d = 1'b1;
                    dbz_d  = 1'b0;
                end
            end
            DIV_RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CNT_W'(1);
            end
            DIV_FIN: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                // zero divisor skipped RUN, so quo_q still holds the captured dividend
                if (zdiv_q) begin
                    quotient_d  = '1;
                    remainder_d = quo_q;
                    dbz_d       = 1'b1;
                end else begin
                    quotient_d  = quo_q;
                    remainder_d = rem_q[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    assign div_if.quotient    = quotient_q;
    assign div_if.remainder   = remainder_q;
    assign div_if.busy        = busy_q;
    assign div_if.done        = done_q;
    assign div_if.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: directed vectors push expectations, a monitor checks on done.
module tb_seq_restoring_divider;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   n_issued = 0;
    int   n_done = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           due;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    seq_restoring_divider_if #(.WIDTH(W)) dut_if ();

    seq_restoring_divider #(.WIDTH(W), .CNT_W(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .div_if (dut_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && dut_if.done) begin
            n_done++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done with nothing pending at cycle %0d, want none", cyc);
            end else begin
                e = sb.pop_front();
                chk("quotient", 64'(dut_if.quotient), 64'(e.q));
                chk("remainder", 64'(dut_if.remainder), 64'(e.r));
                chk("div_by_zero", 64'(dut_if.div_by_zero), 64'(e.z));
                chk("done_latency", 64'(cyc), 64'(e.due));
                if (!e.z) begin
                    chk("q_times_d_plus_r",
                        64'(dut_if.quotient) * 64'(e.b) + 64'(dut_if.remainder), 64'(e.a));
                    chk("rem_below_divisor", 64'(dut_if.remainder < e.b), 64'd1);
                end
            end
        end
    end

    // Call at a negedge with the DUT idle; returns at the negedge after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
        exp_t x;
        x.a = a; x.b = b; x.q = q; x.r = r; x.z = z;
        x.due = cyc + 1 + (z ? 1 : 33);
        dut_if.start    = 1'b1;
        dut_if.dividend = a;
        dut_if.divisor  = b;
        sb.push_back(x);
        n_issued++;
        @(negedge clk);
        dut_if.start = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d results pending, want 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_done_pulse();
        int n = 0;
        while (!dut_if.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!dut_if.done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done pulse, want one");
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    vec_t b2b[$];

    initial begin
        int k;
        dut_if.start    = 1'b0;
        dut_if.dividend = '0;
        dut_if.divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_quotient", 64'(dut_if.quotient), 64'd0);
        chk("rst_remainder", 64'(dut_if.remainder), 64'd0);
        chk("rst_busy", 64'(dut_if.busy), 64'd0);
        chk("rst_done", 64'(dut_if.done), 64'd0);
        chk("rst_dbz", 64'(dut_if.div_by_zero), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // basic 100/7 with busy window
        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        chk("busy_first", 64'(dut_if.busy), 64'd1);
        repeat (32) @(negedge clk);
        chk("busy_last", 64'(dut_if.busy), 64'd1);
        @(negedge clk);
        chk("busy_clear", 64'(dut_if.busy), 64'd0);
        wait_drain();

        // zero divide, flag holds, then clears on next start
        issue(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        wait_drain();
        repeat (3) @(negedge clk);
        chk("dbz_hold", 64'(dut_if.div_by_zero), 64'd1);
        issue(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        chk("dbz_cleared_on_start", 64'(dut_if.div_by_zero), 64'd0);
        wait_drain();

        issue(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        wait_drain();
        issue(32'd3, 32'd10, 32'd0, 32'd3, 1'b0);
        wait_drain();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        wait_drain();

        // start while busy is ignored
        issue(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
        k = cyc;
        while (cyc < k + 9) @(negedge clk);
        dut_if.start    = 1'b1;
        dut_if.dividend = 32'd7;
        dut_if.divisor  = 32'd7;
        @(negedge clk);
        dut_if.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("held_quotient", 64'(dut_if.quotient), 64'h8000_0000 >> 32);
        chk("held_remainder", 64'(dut_if.remainder), 64'h8000_0000);
        wait_drain();
        repeat (40) @(negedge clk);

        // reset mid-operation discards the result
        issue(32'd50, 32'd4, 32'd12, 32'd2, 1'b0);
        k = cyc;
        while (cyc < k + 14) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_quotient", 64'(dut_if.quotient), 64'd0);
        chk("midrst_remainder", 64'(dut_if.remainder), 64'd0);
        chk("midrst_busy", 64'(dut_if.busy), 64'd0);
        chk("midrst_done", 64'(dut_if.done), 64'd0);
        chk("midrst_dbz", 64'(dut_if.div_by_zero), 64'd0);
        sb.delete();
        n_issued--;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        issue(32'd50, 32'd4, 32'd12, 32'd2, 1'b0);
        wait_drain();

        // back-to-back: each start asserted in the cycle of the previous done pulse
        b2b.push_back('{32'd12345678, 32'd1000, 32'd12345, 32'd678, 1'b0});
        b2b.push_back('{32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0});
        b2b.push_back('{32'd1000000, 32'd7, 32'd142857, 32'd1, 1'b0});
        b2b.push_back('{32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 1'b1});
        b2b.push_back('{32'd0, 32'd5, 32'd0, 32'd0, 1'b0});
        b2b.push_back('{32'd17, 32'd17, 32'd1, 32'd0, 1'b0});
        b2b.push_back('{32'h8000_0000, 32'd2, 32'h4000_0000, 32'd0, 1'b0});
        b2b.push_back('{32'd65535, 32'd256, 32'd255, 32'd255, 1'b0});
        issue(b2b[0].a, b2b[0].b, b2b[0].q, b2b[0].r, b2b[0].z);
        for (int i = 1; i < b2b.size(); i++) begin
            wait_done_pulse();
            issue(b2b[i].a, b2b[i].b, b2b[i].q, b2b[i].r, b2b[i].z);
        end
        wait_drain();
        repeat (5) @(negedge clk);

        chk("done_count", 64'(n_done), 64'(n_issued));
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end
endmodule
